// File: rtl/edge_pwm_pkg.sv
// Shared constants for the edge-aligned PWM block.
package edge_pwm_pkg;
    localparam int DUTY_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/edge_pwm.sv
// Edge-aligned (sawtooth) PWM: free-running counter, period-boundary duty shadow,
// and a registered compare output that lags the counter by one clock.
module edge_pwm
    import edge_pwm_pkg::*;
#(
    parameter int DUTY_WIDTH = DUTY_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DUTY_WIDTH-1:0] duty,
    output logic                  pwm_out
);

    localparam logic [DUTY_WIDTH-1:0] PERIOD_MAX = {DUTY_WIDTH{1'b1}};
    localparam logic [DUTY_WIDTH-1:0] CNT_STEP   = DUTY_WIDTH'(1);

    logic [DUTY_WIDTH-1:0] cnt_reg;
    logic [DUTY_WIDTH-1:0] duty_act_reg;
    logic                  pwm_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg      <= '0;
            duty_act_reg <= '0;
            pwm_reg      <= 1'b0;
        end else begin
            cnt_reg <= cnt_reg + CNT_STEP;
            // Duty is only adopted at the wrap, so a mid-period write never reshapes the pulse.
            if (cnt_reg == PERIOD_MAX) begin
                duty_act_reg <= duty;
            end
            pwm_reg <= (cnt_reg < duty_act_reg);
        end
    end

    assign pwm_out = pwm_reg;

endmodule

// File: tb/tb_edge_pwm.sv
// Self-checking bench for edge_pwm: period-indexed duty model plus directed boundary steps.
module tb_edge_pwm;
    localparam int W = 8;
    localparam int P = 256;

    logic         clk  = 1'b0;
    logic         rst  = 1'b0;
    logic [W-1:0] duty = '0;
    logic         pwm_out;

    edge_pwm #(.DUTY_WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .duty    (duty),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   n      = 0;      // clock edges since reset release
    int   dq[$];           // dq[p] = duty in force for period p
    int   hi_cnt = 0;
    logic exp_pwm = 1'b0;

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Period p = n/P, position = n%P; high while position < duty of period p.
    task automatic step();
        int pos;
        int p;
        pos = -1;
        p   = 0;
        @(posedge clk);
        if (!rst) begin
            n = 0;
            dq.delete();
            dq.push_back(0);
            hi_cnt  = 0;
            exp_pwm = 1'b0;
        end else begin
            pos     = n % P;
            p       = n / P;
            exp_pwm = (pos < dq[p]);
            if (pos == P - 1) dq.push_back(int'(duty));
            n++;
        end
        #1;
        check_bit("pwm", pwm_out, exp_pwm);
        if (rst) begin
            hi_cnt += int'(pwm_out);
            if (pos == P - 1) begin
                check_int("period_high", hi_cnt, dq[p]);
                hi_cnt = 0;
            end
        end
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic wait_cnt(input int target, input string tag);
        int k;
        k = 0;
        while ((n % P) != target && k < 2 * P) begin
            step();
            k++;
        end
        check_int(tag, n % P, target);
    endtask

    // Sum pwm_out over one whole period starting at the next wrap.
    task automatic tally_period(input string tag, input int expv);
        int s;
        s = 0;
        wait_cnt(0, {tag, "_align"});
        for (int i = 0; i < P; i++) begin
            step();
            s += int'(pwm_out);
        end
        check_int(tag, s, expv);
    endtask

    int sweep[6] = '{16, 32, 64, 128, 192, 255};

    initial begin
        // 1: reset, then duty 0
        rst  = 1'b0;
        duty = '0;
        run(5);
        check_bit("rst_pwm_low", pwm_out, 1'b0);
        rst = 1'b1;
        run(3000);

        // 2: duty 8, rising edge one clock after wrap
        duty = 8'(8);
        run(600);
        tally_period("t2_high8", 8);
        wait_cnt(0, "t2_align");
        check_bit("t2_low_before_rise", pwm_out, 1'b0);
        step();
        check_bit("t2_rise_after_cnt0", pwm_out, 1'b1);
        run(2000);

        // 3: sweep
        foreach (sweep[i]) begin
            duty = 8'(sweep[i]);
            run(600);
            tally_period($sformatf("t3_high%0d", sweep[i]), sweep[i]);
            run(2000);
        end

        // 4: mid-period change 64 -> 200 with cnt==100
        duty = 8'(64);
        run(600);
        wait_cnt(100, "t4_at100");
        begin
            int s;
            s = hi_cnt;
            duty = 8'(200);
            while ((n % P) != 0) begin
                step();
                s += int'(pwm_out);
            end
            check_int("t4_current_stays64", s, 64);
        end
        tally_period("t4_next200", 200);

        // 5: reset while high at cnt==50
        duty = 8'(100);
        run(600);
        wait_cnt(50, "t5_at50");
        check_bit("t5_high_before_rst", pwm_out, 1'b1);
        rst = 1'b0;
        step();
        check_bit("t5_low_after_rst", pwm_out, 1'b0);
        run(3);
        rst = 1'b1;
        begin
            int s;
            s = 0;
            for (int i = 0; i < P; i++) begin
                step();
                s += int'(pwm_out);
            end
            check_int("t5_first_period_low", s, 0);
        end
        tally_period("t5_second_period", 100);

        // 6: single-cycle pulse and single-cycle gap
        duty = 8'(1);
        run(600);
        tally_period("t6_duty1", 1);
        duty = 8'(255);
        run(600);
        tally_period("t6_duty255", 255);

        // random held duties
        for (int i = 0; i < 12; i++) begin
            duty = 8'($urandom_range(0, 255));
            run($urandom_range(1, 700));
        end
        // duty toggling every cycle: only the wrap-edge value may matter
        for (int i = 0; i < 1500; i++) begin
            duty = 8'($urandom_range(0, 255));
            step();
        end
        run(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
